counter_sequencer: RTL and testbench
====================================

Name: counter_sequencer

Overview:
Controller that owns and sequences the 10-bit LED counter datapath from debounced button event pulses. It arbitrates simultaneous commands (load preset / single-step / run-hold / direction), generates the count-enable tick from a prescaler, and drives the counter value consumed by the binary and Gray LED outputs. It sits between the debounce instances and the LED output logic, on the single system clock.

Parameters:
CNT_W, 10, counter width in bits.
DIV_W, 23, prescaler width; RUN advances once per 2^DIV_W clocks.
LIMIT, 10'h3FF, terminal count used by the optional auto-stop feature.

Ports:
CLK  input  1  system clock; all logic on its rising edge.
RST  input  1  synchronous, active-high reset.
CMD_RUN  input  1  one-cycle pulse; toggles RUN/HOLD.
CMD_STEP  input  1  one-cycle pulse; single count in HOLD.
CMD_DIR  input  1  level; 0 = count up, 1 = count down.
CMD_LOAD  input  1  one-cycle pulse; load preset selected by LOAD_SEL.
LOAD_SEL  input  2  preset select: 0 -> 10'h000, 1 -> 10'h155, 2 -> 10'h2AA, 3 -> 10'h3FF.
COUNT  output  CNT_W  current counter value.
STATE  output  2  FSM state encoding (HOLD=0, RUN=1, STEP=2, LOAD=3).
TICK  output  1  one-cycle prescaler wrap pulse; also drives the activity indicator.
WRAP  output  1  one-cycle pulse when COUNT wraps (3FF->000 up, 000->3FF down).
DONE  output  1  one-cycle auto-stop pulse (feature only; tied 0 otherwise).

Behaviour:
- Reset (RST=1 at posedge): COUNT=0, STATE=HOLD, prescaler=0, TICK=WRAP=DONE=0. Reset wins over every command in the same cycle.
- Prescaler: free-running DIV_W-bit counter, never gated by STATE. TICK=1 for exactly the cycle after the prescaler value 2^DIV_W-1.
- FSM:
  - HOLD: COUNT is frozen. CMD_LOAD -> LOAD. Else CMD_STEP -> STEP. Else CMD_RUN -> RUN.
  - RUN: on each TICK, COUNT +/- 1 per CMD_DIR sampled in that cycle. CMD_LOAD -> LOAD. Else CMD_RUN -> HOLD. CMD_STEP is ignored.
  - STEP: lasts 1 cycle. COUNT +/- 1 once, then -> HOLD.
  - LOAD: lasts 1 cycle. COUNT <= preset(LOAD_SEL captured with the CMD_LOAD pulse), then -> HOLD. LOAD always exits to HOLD, including when entered from RUN.
- Arbitration: priority is LOAD > STEP > RUN. Lower-priority pulses in the same cycle are dropped, not queued. Commands arriving while in STEP or LOAD are dropped.
- Latency: the command pulse at cycle n produces a STATE change at n+1 and a COUNT change at n+2 (STEP/LOAD). In RUN, COUNT updates in the cycle after TICK.
- Arithmetic: modulo 2^CNT_W. WRAP pulses in the same cycle COUNT takes the wrapped value. A LOAD never asserts WRAP.
- A TICK coinciding with a CMD_RUN that leaves RUN: the count is applied, then the state changes to HOLD.
- CMD_DIR change mid-RUN takes effect at the next TICK.

Optional Feature:
COUNTER_SEQ_AUTOSTOP_EN
- Defined: in RUN, when a TICK update makes COUNT == LIMIT, the FSM goes to HOLD in that same update and DONE pulses 1 cycle. STEP and LOAD reaching LIMIT do not assert DONE.
- Undefined: LIMIT is unused, DONE is tied 0, and RUN continues through wrap.

Decomposition:
- Package counter_pkg: state encoding constants (HOLD/RUN/STEP/LOAD), the four preset constants (10'h000, 10'h155, 10'h2AA, 10'h3FF), and the direction constants.
- One sub-module, tick_gen: prescaler plus TICK pulse, parameterised by DIV_W. The FSM, arbitration and counter stay in counter_sequencer.

Test Plan:
- DIV_W=2. Reset, then CMD_RUN, wait 40 clocks -> COUNT increments every 4 clocks, reaching 10 (±1 for phase); STATE=1 throughout.
- HOLD, COUNT=10'h3FF via LOAD_SEL=3, CMD_DIR=0, CMD_STEP -> COUNT=10'h000, WRAP pulse 1 cycle, STATE returns to 0.
- HOLD, same-cycle CMD_LOAD(LOAD_SEL=1) + CMD_STEP + CMD_RUN -> COUNT=10'h155, STATE=0 afterwards, no step, no run.
- RUN with COUNT=10'h005, assert RST mid-run -> next cycle COUNT=0, STATE=0, TICK=0, prescaler restarts at 0.
- RUN, CMD_DIR=1, COUNT=10'h001 -> after two TICKs COUNT=10'h3FF with WRAP on the second.
- With COUNTER_SEQ_AUTOSTOP_EN, LIMIT=10'h008, start RUN from 0 -> COUNT stops at 8, DONE pulses once, STATE=0, COUNT stable for 20 further ticks.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared encodings for the LED counter sequencer: FSM states, presets, direction.
package counter_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_LOAD = 2'd3
  } state_e;

  localparam logic [9:0] PRESET_0 = 10'h000;
  localparam logic [9:0] PRESET_1 = 10'h155;
  localparam logic [9:0] PRESET_2 = 10'h2AA;
  localparam logic [9:0] PRESET_3 = 10'h3FF;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  function automatic logic [9:0] preset_value(input logic [1:0] sel);
    case (sel)
      2'd0:    preset_value = PRESET_0;
      2'd1:    preset_value = PRESET_1;
      2'd2:    preset_value = PRESET_2;
      default: preset_value = PRESET_3;
    endcase
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler; TICK is high for the one cycle after the prescaler
// has held its all-ones value.
module tick_gen #(
  parameter int DIV_W = 23
) (
  input  logic CLK,
  input  logic RST,
  output logic TICK
);

  logic [DIV_W-1:0] r_presc;
  logic             r_tick;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, matching real hardware.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_presc <= r_presc + DIV_W'(1);
      r_tick  <= &r_presc;
    end
  end

  assign TICK = r_tick;

endmodule

// File: rtl/counter_sequencer.sv
// Command arbiter and 10-bit LED counter (HOLD/RUN/STEP/LOAD FSM).
// Define COUNTER_SEQ_AUTOSTOP_EN to stop RUN at LIMIT and pulse DONE.
module counter_sequencer
  import counter_pkg::*;
#(
  parameter int CNT_W = 10,
`ifdef COUNTER_SEQ_AUTOSTOP_EN
  parameter logic [CNT_W-1:0] LIMIT = CNT_W'(10'h3FF),
`endif
  parameter int DIV_W = 23
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CMD_RUN,
  input  logic             CMD_STEP,
  input  logic             CMD_DIR,
  input  logic             CMD_LOAD,
  input  logic [1:0]       LOAD_SEL,
  output logic [CNT_W-1:0] COUNT,
  output logic [1:0]       STATE,
  output logic             TICK,
  output logic             WRAP,
  output logic             DONE
);

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic [1:0]       r_load_sel, w_load_sel_nxt;
  logic             r_wrap, w_wrap_nxt;
  logic             w_tick;
  logic             w_adv;
  logic [CNT_W-1:0] w_count_adv;
  logic             w_wrap_adv;

  tick_gen #(.DIV_W(DIV_W)) u_tick_gen (
    .CLK  (CLK),
    .RST  (RST),
    .TICK (w_tick)
  );

  assign w_count_adv = (CMD_DIR == DIR_DOWN) ? r_count - CNT_W'(1) : r_count + CNT_W'(1);
  assign w_wrap_adv  = (CMD_DIR == DIR_DOWN) ? (r_count == '0) : (&r_count);

`ifdef COUNTER_SEQ_AUTOSTOP_EN
  logic r_done, w_done_nxt;
  assign w_done_nxt = (r_state == ST_RUN) && w_tick && (w_count_adv == LIMIT);
`endif

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt    = r_state;
    w_count_nxt    = r_count;
    w_load_sel_nxt = r_load_sel;
    w_wrap_nxt     = 1'b0;
    w_adv          = 1'b0;
    case (r_state)
      ST_HOLD: begin
        if (CMD_LOAD) begin
          w_state_nxt    = ST_LOAD;
          w_load_sel_nxt = LOAD_SEL;
        end else if (CMD_STEP) begin
          w_state_nxt = ST_STEP;
        end else if (CMD_RUN) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_adv = w_tick;
        if (CMD_LOAD) begin
          w_state_nxt    = ST_LOAD;
          w_load_sel_nxt = LOAD_SEL;
        end else if (CMD_RUN) begin
          w_state_nxt = ST_HOLD;
`ifdef COUNTER_SEQ_AUTOSTOP_EN
        end else if (w_done_nxt) begin
          w_state_nxt = ST_HOLD;
`endif
        end
      end
      ST_STEP: begin
        w_adv       = 1'b1;
        w_state_nxt = ST_HOLD;
      end
      ST_LOAD: begin
        w_count_nxt = CNT_W'(preset_value(r_load_sel));
        w_state_nxt = ST_HOLD;
      end
      default: w_state_nxt = ST_HOLD;
    endcase
    // A LOAD never advances, so it can never raise WRAP.
    if (w_adv) begin
      w_count_nxt = w_count_adv;
      w_wrap_nxt  = w_wrap_adv;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= ST_HOLD;
      r_count    <= '0;
      r_load_sel <= 2'd0;
      r_wrap     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_load_sel <= w_load_sel_nxt;
      r_wrap     <= w_wrap_nxt;
    end
  end

`ifdef COUNTER_SEQ_AUTOSTOP_EN
  always_ff @(posedge CLK) begin
    if (RST) r_done <= 1'b0;
    else     r_done <= w_done_nxt;
  end
  assign DONE = r_done;
`else
  assign DONE = 1'b0;
`endif

  assign COUNT = r_count;
  assign STATE = r_state;
  assign TICK  = w_tick;
  assign WRAP  = r_wrap;

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer with a 4-clock prescaler (DIV_W=2).
module tb_counter_sequencer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       CMD_RUN = 1'b0, CMD_STEP = 1'b0, CMD_DIR = 1'b0, CMD_LOAD = 1'b0;
  logic [1:0] LOAD_SEL = 2'd0;
  logic [9:0] COUNT;
  logic [1:0] STATE;
  logic       TICK, WRAP, DONE;

  always #5 CLK = ~CLK;

  counter_sequencer #(
    .CNT_W(10),
`ifdef COUNTER_SEQ_AUTOSTOP_EN
    .LIMIT(10'h008),
`endif
    .DIV_W(2)
  ) dut (
    .CLK(CLK), .RST(RST), .CMD_RUN(CMD_RUN), .CMD_STEP(CMD_STEP),
    .CMD_DIR(CMD_DIR), .CMD_LOAD(CMD_LOAD), .LOAD_SEL(LOAD_SEL),
    .COUNT(COUNT), .STATE(STATE), .TICK(TICK), .WRAP(WRAP), .DONE(DONE)
  );

  typedef struct {
    int         due;
    string      name;
    logic [9:0] count;
    logic [1:0] state;
    logic       wrap;
    logic       done;
  } exp_t;

  exp_t sb_q[$];
  exp_t m_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Expectations are due at the cycle whose posedge produced the value.
  always @(negedge CLK) begin
    while (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
      m_e = sb_q.pop_front();
      n_checks++;
      if (m_e.due != cyc) begin
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d missed at cycle %0d", m_e.name, m_e.due, cyc);
      end else if (COUNT !== m_e.count || STATE !== m_e.state || WRAP !== m_e.wrap || DONE !== m_e.done) begin
        n_fail++;
        $display("FAIL %s cyc+%0d: got count=%h state=%0d wrap=%b done=%b, want count=%h state=%0d wrap=%b done=%b",
                 m_e.name, cyc, COUNT, STATE, WRAP, DONE, m_e.count, m_e.state, m_e.wrap, m_e.done);
      end
    end
  end

  function automatic void push(int due, string name, int c, logic [1:0] s, logic w, logic d);
    exp_t e;
    e.due = due; e.name = name; e.count = 10'(c); e.state = s; e.wrap = w; e.done = d;
    sb_q.push_back(e);
  endfunction

  task automatic clk1();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    CMD_RUN = 1'b0; CMD_STEP = 1'b0; CMD_LOAD = 1'b0; CMD_DIR = 1'b0; LOAD_SEL = 2'd0;
    clk1();
    RST = 1'b0;
  endtask

  task automatic drain(string name);
    for (int i = 0; i < 400 && sb_q.size() != 0; i++) clk1();
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: %0d expectations never reached, want 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    int c0;
    RST = 1'b1; CMD_RUN = 1'b1; CMD_LOAD = 1'b1; CMD_STEP = 1'b1; LOAD_SEL = 2'd3;
    clk1();
    clk1();
    n_checks++;
    if (COUNT !== 10'h000 || STATE !== 2'd0 || TICK !== 1'b0 || WRAP !== 1'b0 || DONE !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got count=%h state=%0d tick=%b wrap=%b done=%b, want 000/0/0/0/0",
               COUNT, STATE, TICK, WRAP, DONE);
    end
    RST = 1'b0; CMD_RUN = 1'b0; CMD_LOAD = 1'b0; CMD_STEP = 1'b0; LOAD_SEL = 2'd0;
    c0 = cyc;
    for (int t = 1; t <= 8; t++) push(c0 + t, "reset_hold", 0, 2'd0, 1'b0, 1'b0);
    for (int t = 1; t <= 8; t++) begin
      clk1();
      n_checks++;
      if (TICK !== ((t % 4) == 0)) begin
        n_fail++;
        $display("FAIL reset_tick t=%0d: got %b want %b", t, TICK, (t % 4) == 0);
      end
    end
    drain("reset");
  endtask

  task automatic test_run();
    int c0;
    do_reset();
    c0 = cyc;
    for (int t = 1; t <= 41; t++) push(c0 + t, "run_up", (t - 1) / 4, 2'd1, 1'b0, 1'b0);
    CMD_RUN = 1'b1;
    clk1();
    CMD_RUN = 1'b0;
    repeat (40) clk1();
    drain("run_up");
  endtask

  task automatic test_step_wrap();
    int c0;
    do_reset();
    c0 = cyc;
    push(c0 + 1, "load3ff", 0, 2'd3, 1'b0, 1'b0);
    push(c0 + 2, "load3ff", 10'h3FF, 2'd0, 1'b0, 1'b0);
    push(c0 + 3, "step_wrap", 10'h3FF, 2'd2, 1'b0, 1'b0);
    push(c0 + 4, "step_wrap", 0, 2'd0, 1'b1, 1'b0);
    push(c0 + 5, "step_wrap", 0, 2'd0, 1'b0, 1'b0);
    LOAD_SEL = 2'd3; CMD_LOAD = 1'b1;
    clk1();
    CMD_LOAD = 1'b0;
    clk1();
    CMD_STEP = 1'b1;
    clk1();
    CMD_STEP = 1'b0;
    clk1();
    clk1();
    drain("step_wrap");
  endtask

  task automatic test_priority();
    int c0;
    do_reset();
    c0 = cyc;
    push(c0 + 1, "prio", 0, 2'd3, 1'b0, 1'b0);
    for (int t = 2; t <= 12; t++) push(c0 + t, "prio", 10'h155, 2'd0, 1'b0, 1'b0);
    LOAD_SEL = 2'd1; CMD_LOAD = 1'b1; CMD_STEP = 1'b1; CMD_RUN = 1'b1;
    clk1();
    CMD_LOAD = 1'b0; CMD_STEP = 1'b0; CMD_RUN = 1'b0; LOAD_SEL = 2'd2;
    repeat (11) clk1();
    drain("prio");
  endtask

  task automatic test_back_to_back();
    int c0;
    do_reset();
    c0 = cyc;
    push(c0 + 1, "drop_in_step", 0, 2'd2, 1'b0, 1'b0);
    for (int t = 2; t <= 10; t++) push(c0 + t, "drop_in_step", 1, 2'd0, 1'b0, 1'b0);
    CMD_STEP = 1'b1;
    clk1();
    CMD_STEP = 1'b0; CMD_RUN = 1'b1; CMD_LOAD = 1'b1;
    clk1();
    CMD_RUN = 1'b0; CMD_LOAD = 1'b0;
    repeat (8) clk1();
    drain("drop_in_step");
  endtask

  task automatic test_reset_mid_run();
    int c0;
    do_reset();
    c0 = cyc;
    for (int t = 1; t <= 22; t++) push(c0 + t, "run_to_5", (t - 1) / 4, 2'd1, 1'b0, 1'b0);
    for (int t = 23; t <= 30; t++) push(c0 + t, "mid_reset", 0, 2'd0, 1'b0, 1'b0);
    CMD_RUN = 1'b1;
    clk1();
    CMD_RUN = 1'b0;
    repeat (21) clk1();
    RST = 1'b1;
    clk1();
    RST = 1'b0;
    for (int t = 23; t <= 30; t++) begin
      n_checks++;
      if (TICK !== (t == 27)) begin
        n_fail++;
        $display("FAIL mid_reset_tick t=%0d: got %b want %b", t, TICK, t == 27);
      end
      if (t < 30) clk1();
    end
    drain("mid_reset");
  endtask

  task automatic test_down_wrap();
    int c0;
    do_reset();
    c0 = cyc;
    push(c0 + 1, "down_step", 0, 2'd2, 1'b0, 1'b0);
    push(c0 + 2, "down_step", 1, 2'd0, 1'b0, 1'b0);
    push(c0 + 3, "down_run", 1, 2'd1, 1'b0, 1'b0);
    push(c0 + 4, "down_run", 1, 2'd1, 1'b0, 1'b0);
    for (int t = 5; t <= 8; t++) push(c0 + t, "down_run", 0, 2'd1, 1'b0, 1'b0);
    push(c0 + 9, "down_wrap", 10'h3FF, 2'd1, 1'b1, 1'b0);
    push(c0 + 10, "down_wrap", 10'h3FF, 2'd1, 1'b0, 1'b0);
    CMD_STEP = 1'b1;
    clk1();
    CMD_STEP = 1'b0;
    clk1();
    CMD_DIR = 1'b1; CMD_RUN = 1'b1;
    clk1();
    CMD_RUN = 1'b0;
    repeat (7) clk1();
    drain("down_wrap");
    CMD_DIR = 1'b0;
  endtask

`ifdef COUNTER_SEQ_AUTOSTOP_EN
  task automatic test_autostop();
    int c0;
    do_reset();
    c0 = cyc;
    for (int t = 1; t <= 32; t++) push(c0 + t, "autostop_run", (t - 1) / 4, 2'd1, 1'b0, 1'b0);
    push(c0 + 33, "autostop_hit", 8, 2'd0, 1'b0, 1'b1);
    for (int t = 34; t <= 113; t++) push(c0 + t, "autostop_hold", 8, 2'd0, 1'b0, 1'b0);
    CMD_RUN = 1'b1;
    clk1();
    CMD_RUN = 1'b0;
    repeat (112) clk1();
    drain("autostop");
  endtask
`endif

  initial begin
    test_reset();
`ifdef COUNTER_SEQ_AUTOSTOP_EN
    test_autostop();
`else
    test_run();
`endif
    test_step_wrap();
    test_priority();
    test_back_to_back();
    test_reset_mid_run();
    test_down_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
